// File: rtl/cmd_responder.sv
// cmd_responder: target endpoint of the 204-bit configuration command bus.
// Decodes write/read commands addressed to MODULE_ID, maintains a local
// 32-bit register bank with write/read counters, and returns a two-stage
// pipelined read acknowledge word for every handled read.
module cmd_responder #(
   parameter logic [7:0]  MODULE_ID = 8'h01,
   parameter int unsigned REG_NUM   = 16
) (
   input  logic                   i_clk,
   input  logic                   w_core_rst_n,
   input  logic [203:0]           iv_wr_command,
   input  logic                   i_wr_command_wr,
   input  logic [203:0]           iv_rd_command,
   input  logic                   i_rd_command_wr,
   output logic [203:0]           ov_rd_command_ack,
   output logic                   o_rd_command_ack_wr,
   output logic [REG_NUM*32-1:0]  ov_cfg_regs,
   output logic                   o_cfg_update
);

   localparam logic [3:0]  TYPE_WR   = 4'h1;
   localparam logic [3:0]  TYPE_RD   = 4'h2;
   localparam logic [3:0]  ACK_OK    = 4'h3;
   localparam logic [3:0]  ACK_ERR   = 4'hF;
   localparam logic [31:0] ADDR_WCNT = 32'(REG_NUM);
   localparam logic [31:0] ADDR_RCNT = 32'(REG_NUM + 1);

   // command field decode
   logic [3:0]  wr_type;
   logic [7:0]  wr_id;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  rd_type;
   logic [7:0]  rd_id;
   logic [31:0] rd_addr;
   logic        wr_hit;
   logic        rd_hit;

   assign wr_type = iv_wr_command[203:200];
   assign wr_id   = iv_wr_command[199:192];
   assign wr_addr = iv_wr_command[191:160];
   assign wr_data = iv_wr_command[31:0];
   assign rd_type = iv_rd_command[203:200];
   assign rd_id   = iv_rd_command[199:192];
   assign rd_addr = iv_rd_command[191:160];

   assign wr_hit = i_wr_command_wr && (wr_type == TYPE_WR) && (wr_id == MODULE_ID)
                   && (wr_addr < ADDR_WCNT);
   assign rd_hit = i_rd_command_wr && (rd_type == TYPE_RD) && (rd_id == MODULE_ID);

   // reserved fields and read-command data carry no meaning here
   logic unused_cmd_bits;
   assign unused_cmd_bits = ^{iv_wr_command[159:32], iv_rd_command[159:0]};

   // state
   logic [REG_NUM-1:0][31:0] regs_q, regs_d;
   logic [31:0]              wr_cnt_q, wr_cnt_d;
   logic [31:0]              rd_cnt_q, rd_cnt_d;
   logic                     cfg_update_q, cfg_update_d;
   logic                     s1_vld_q, s1_vld_d;
   logic [31:0]              s1_addr_q, s1_addr_d;
   logic [203:0]             ack_q, ack_d;
   logic                     ack_wr_q, ack_wr_d;

   // read mux result for the command held in S1
   logic        rd_ok;
   logic [31:0] rd_data;

   // write path: apply accepted write, bump wr_cnt, flag the update
   always_comb begin
      regs_d       = regs_q;
      wr_cnt_d     = wr_cnt_q;
      cfg_update_d = 1'b0;
      if (wr_hit) begin
         for (int unsigned k = 0; k < REG_NUM; k++) begin
            if (wr_addr == 32'(k)) begin
               regs_d[k] = wr_data;
            end
         end
         wr_cnt_d     = wr_cnt_q + 32'd1;
         cfg_update_d = 1'b1;
      end
   end

   // S2 read mux; sources the next-state bank/wr_cnt so a write strobed in
   // the same cycle the read sits in S1 is already visible in the ack
   always_comb begin
      rd_ok   = 1'b0;
      rd_data = '0;
      for (int unsigned k = 0; k < REG_NUM; k++) begin
         if (s1_addr_q == 32'(k)) begin
            rd_ok   = 1'b1;
            rd_data = regs_d[k];
         end
      end
      if (s1_addr_q == ADDR_WCNT) begin
         rd_ok   = 1'b1;
         rd_data = wr_cnt_d;
      end else if (s1_addr_q == ADDR_RCNT) begin
         rd_ok   = 1'b1;
         rd_data = rd_cnt_q;
      end
   end

   // read pipeline: S1 captures the decoded command, S2 forms and registers the ack
   always_comb begin
      s1_vld_d  = rd_hit;
      s1_addr_d = rd_hit ? rd_addr : s1_addr_q;
      ack_d     = ack_q;
      ack_wr_d  = 1'b0;
      rd_cnt_d  = rd_cnt_q;
      if (s1_vld_q) begin
         ack_wr_d = 1'b1;
         ack_d    = {(rd_ok ? ACK_OK : ACK_ERR), MODULE_ID, s1_addr_q, 128'd0,
                     (rd_ok ? rd_data : 32'd0)};
         if (rd_ok) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
         end
      end
   end

   // state registers, asynchronous active-low reset
   always_ff @(posedge i_clk or negedge w_core_rst_n) begin
      if (!w_core_rst_n) begin
         regs_q       <= '0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         cfg_update_q <= 1'b0;
         s1_vld_q     <= 1'b0;
         s1_addr_q    <= '0;
         ack_q        <= '0;
         ack_wr_q     <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         cfg_update_q <= cfg_update_d;
         s1_vld_q     <= s1_vld_d;
         s1_addr_q    <= s1_addr_d;
         ack_q        <= ack_d;
         ack_wr_q     <= ack_wr_d;
      end
   end

   assign ov_cfg_regs         = regs_q;
   assign o_cfg_update        = cfg_update_q;
   assign ov_rd_command_ack   = ack_q;
   assign o_rd_command_ack_wr = ack_wr_q;

endmodule

// File: tb/tb_cmd_responder.sv
// tb_cmd_responder: directed and randomized checks of cmd_responder against
// a behavioural model (array bank, counters, pending-read slot).
module tb_cmd_responder;

   localparam logic [7:0]  MID = 8'h01;
   localparam int unsigned RN  = 16;
   localparam int unsigned CW  = RN * 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [203:0]   wr_cmd = '0;
   logic           wr_wr = 1'b0;
   logic [203:0]   rd_cmd = '0;
   logic           rd_wr = 1'b0;
   logic [203:0]   ack;
   logic           ack_wr;
   logic [CW-1:0]  cfg_regs;
   logic           cfg_update;

   cmd_responder #(.MODULE_ID(MID), .REG_NUM(RN)) dut (
      .i_clk               (clk),
      .w_core_rst_n        (rst_n),
      .iv_wr_command       (wr_cmd),
      .i_wr_command_wr     (wr_wr),
      .iv_rd_command       (rd_cmd),
      .i_rd_command_wr     (rd_wr),
      .ov_rd_command_ack   (ack),
      .o_rd_command_ack_wr (ack_wr),
      .ov_cfg_regs         (cfg_regs),
      .o_cfg_update        (cfg_update)
   );

   always #4 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // model state
   logic [31:0]  m_regs [RN];
   logic [31:0]  m_wcnt, m_rcnt;
   bit           pend_vld;
   logic [31:0]  pend_addr;
   bit           exp_upd, exp_ack_wr;
   logic [203:0] exp_ack;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [203:0] make_cmd(input logic [3:0] t, input logic [7:0] id,
                                             input logic [31:0] a, input logic [31:0] d);
      logic [127:0] junk;
      junk = {$urandom, $urandom, $urandom, $urandom};
      return {t, id, a, junk, d};
   endfunction

   function automatic logic [CW-1:0] model_bank();
      logic [CW-1:0] v;
      for (int k = 0; k < RN; k++) v[32*k +: 32] = m_regs[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < RN; k++) m_regs[k] = '0;
      m_wcnt = '0; m_rcnt = '0;
      pend_vld = 0; pend_addr = '0;
      exp_upd = 0; exp_ack_wr = 0; exp_ack = '0;
   endtask

   // expected ack for a read of address a against the current model state
   task automatic model_read(input logic [31:0] a, output logic [203:0] w);
      logic [31:0] d;
      bit ok;
      ok = 1;
      if (a < RN)          d = m_regs[a];
      else if (a == RN)    d = m_wcnt;
      else if (a == RN+1)  d = m_rcnt;
      else begin ok = 0; d = '0; end
      if (ok) m_rcnt++;
      w = {(ok ? 4'h3 : 4'hF), MID, a, 128'd0, d};
   endtask

   // one clock cycle: drive, advance model at the edge, compare mid-cycle
   task automatic cycle(input bit we, input logic [203:0] wc, input bit re, input logic [203:0] rc);
      wr_cmd = wc; wr_wr = we; rd_cmd = rc; rd_wr = re;
      @(posedge clk);
      exp_upd = 0;
      if (we && wc[203:200] == 4'h1 && wc[199:192] == MID && wc[191:160] < RN) begin
         m_regs[wc[191:160]] = wc[31:0];
         m_wcnt++;
         exp_upd = 1;
      end
      exp_ack_wr = 0;
      if (pend_vld) begin
         model_read(pend_addr, exp_ack);
         exp_ack_wr = 1;
      end
      pend_vld  = re && rc[203:200] == 4'h2 && rc[199:192] == MID;
      pend_addr = rc[191:160];
      @(negedge clk);
      wr_wr = 0; rd_wr = 0;
      check("cfg_update", cfg_update, exp_upd);
      check("ack_wr", ack_wr, exp_ack_wr);
      check("ack_word", ack, exp_ack);
      check("cfg_regs", cfg_regs, model_bank());
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cycle(1, make_cmd(4'h1, MID, a, d), 0, '0);
   endtask

   task automatic rd(input logic [31:0] a);
      cycle(0, '0, 1, make_cmd(4'h2, MID, a, $urandom));
   endtask

   task automatic idle();
      cycle(0, '0, 0, '0);
   endtask

   // asynchronous reset held across two falling edges, outputs checked while low
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_ack", ack, 204'd0);
      check("rst_ack_wr", ack_wr, 1'b0);
      check("rst_update", cfg_update, 1'b0);
      check("rst_regs", cfg_regs, '0);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      logic [3:0]  t;
      logic [7:0]  id;
      logic [31:0] a;
      model_reset();
      @(negedge clk);
      do_reset();

      // basic write/read
      wr(3, 32'hA5A5_0001);
      check("basic_reg3", cfg_regs[127:96], 32'hA5A5_0001);
      rd(3);
      idle();
      check("basic_ack_wr", ack_wr, 1'b1);
      check("basic_ack_type", ack[203:200], 4'h3);
      check("basic_ack_data", ack[31:0], 32'hA5A5_0001);

      // filtering
      do_reset();
      cycle(1, make_cmd(4'h1, MID + 8'd1, 2, 32'hDEAD), 0, '0);
      wr(RN, 32'h1111);
      wr(RN + 1, 32'h2222);
      cycle(1, make_cmd(4'h2, MID, 2, 32'h3333), 0, '0);
      cycle(0, '0, 1, make_cmd(4'h2, MID + 8'd1, 2, 0));
      repeat (10) idle();
      rd(RN);
      idle();
      check("filter_wcnt", ack[31:0], 32'd0);
      check("filter_regs", cfg_regs, '0);

      // error and counters
      do_reset();
      rd(RN + 2);
      idle();
      check("err_type", ack[203:200], 4'hF);
      check("err_data", ack[31:0], 32'd0);
      wr(0, 32'h10); wr(1, 32'h20);
      rd(0); idle();
      rd(RN + 1); idle();
      check("cnt_rcnt", ack[31:0], 32'd1);
      rd(RN); idle();
      check("cnt_wcnt", ack[31:0], 32'd2);

      // back-to-back reads
      do_reset();
      for (int k = 0; k < 8; k++) wr(k, 32'(k * 32'h11));
      n = 0;
      for (int k = 0; k < 8; k++) begin
         rd(k);
         if (ack_wr) n++;
      end
      repeat (2) begin
         idle();
         if (ack_wr) n++;
      end
      check("b2b_count", n, 8);

      // same-cycle write/read hazard
      cycle(1, make_cmd(4'h1, MID, 5, 32'h1234), 1, make_cmd(4'h2, MID, 5, 0));
      idle();
      check("hazard_data", ack[31:0], 32'h1234);

      // reset mid-flight
      wr(5, 32'h55);
      rd(5);
      do_reset();
      repeat (4) idle();
      rd(5); idle();
      check("rst_reg5", ack[31:0], 32'd0);
      rd(RN); idle();
      check("rst_wcnt", ack[31:0], 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [203:0] wc, rc;
         bit we, re;
         t  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h1;
         id = ($urandom_range(0, 7) == 0) ? MID + 8'd1 : MID;
         a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, RN + 3));
         wc = make_cmd(t, id, a, $urandom);
         t  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h2;
         id = ($urandom_range(0, 7) == 0) ? MID + 8'd1 : MID;
         a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, RN + 3));
         rc = make_cmd(t, id, a, $urandom);
         we = ($urandom_range(0, 1) == 1);
         re = ($urandom_range(0, 2) != 0);
         cycle(we, wc, re, rc);
      end
      repeat (3) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
